// File: rtl/laser_point_driver.sv
// laser_point_driver: holds a point pattern, streams it into the LASER core
// after a short core reset, then waits for DONE and reports the two captured
// circle centres together with the DONE latency, a timeout flag and a
// protocol-error flag.
module laser_point_driver #(
   parameter int NPTS    = 40,
   parameter int TIMEOUT = 4096,
   parameter int CNTW    = 16
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            wr_en,
   input  logic [5:0]      wr_addr,
   input  logic [3:0]      wr_x,
   input  logic [3:0]      wr_y,
   input  logic            start,
   output logic            busy,
   output logic            L_RST,
   output logic [3:0]      L_X,
   output logic [3:0]      L_Y,
   input  logic [3:0]      L_C1X,
   input  logic [3:0]      L_C1Y,
   input  logic [3:0]      L_C2X,
   input  logic [3:0]      L_C2Y,
   input  logic            L_DONE,
   output logic            res_valid,
   output logic [3:0]      res_c1x,
   output logic [3:0]      res_c1y,
   output logic [3:0]      res_c2x,
   output logic [3:0]      res_c2y,
   output logic [CNTW-1:0] res_cycles,
   output logic            timeout,
   output logic            proto_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RSTL,
      S_SEND,
      S_WAIT,
      S_REPORT
   } state_t;

   // Index runs one past the last point, so it needs room for the value NPTS.
   localparam logic [6:0]      LAST    = 7'(NPTS);
   localparam logic [CNTW-1:0] TMO     = CNTW'(TIMEOUT);
   localparam logic [CNTW-1:0] CNT_MAX = '1;

   logic [7:0]      mem [NPTS];
   state_t          state;
   logic            rst_phase;
   logic [6:0]      idx;
   logic [CNTW-1:0] cnt;
   logic [7:0]      rd_pt;

   assign rd_pt = mem[idx[5:0]];

   // Pattern memory: host writes land only while idle and only in range.
   always_ff @(posedge CLK) begin
      if (state == S_IDLE && wr_en && ({1'b0, wr_addr} < LAST)) begin
         mem[wr_addr] <= {wr_x, wr_y};
      end
   end

   // Run sequencer: core reset, point streaming, DONE wait and result report.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= S_IDLE;
         rst_phase  <= 1'b0;
         idx        <= '0;
         cnt        <= '0;
         busy       <= 1'b0;
         L_RST      <= 1'b1;
         L_X        <= '0;
         L_Y        <= '0;
         res_valid  <= 1'b0;
         res_c1x    <= '0;
         res_c1y    <= '0;
         res_c2x    <= '0;
         res_c2y    <= '0;
         res_cycles <= '0;
         timeout    <= 1'b0;
         proto_err  <= 1'b0;
      end else begin
         res_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               L_RST <= 1'b0;
               if (start) begin
                  state     <= S_RSTL;
                  busy      <= 1'b1;
                  timeout   <= 1'b0;
                  proto_err <= 1'b0;
                  idx       <= '0;
                  rst_phase <= 1'b0;
                  L_RST     <= 1'b1;
                  L_X       <= '0;
                  L_Y       <= '0;
               end
            end
            S_RSTL: begin
               // Core reset is held for two cycles, then the first point goes out.
               if (rst_phase) begin
                  state <= S_SEND;
                  L_RST <= 1'b0;
                  L_X   <= rd_pt[7:4];
                  L_Y   <= rd_pt[3:0];
                  idx   <= idx + 7'd1;
               end else begin
                  rst_phase <= 1'b1;
               end
            end
            S_SEND: begin
               // A DONE while points are still going out is a core protocol error.
               if (L_DONE) begin
                  proto_err <= 1'b1;
               end
               if (idx == LAST) begin
                  state <= S_WAIT;
                  cnt   <= {{(CNTW-1){1'b0}}, 1'b1};
               end else begin
                  L_X <= rd_pt[7:4];
                  L_Y <= rd_pt[3:0];
                  idx <= idx + 7'd1;
               end
            end
            S_WAIT: begin
               // DONE is checked before the timeout so a coincident DONE wins.
               if (L_DONE) begin
                  state      <= S_REPORT;
                  busy       <= 1'b0;
                  res_valid  <= 1'b1;
                  res_c1x    <= L_C1X;
                  res_c1y    <= L_C1Y;
                  res_c2x    <= L_C2X;
                  res_c2y    <= L_C2Y;
                  res_cycles <= cnt;
               end else if (cnt >= TMO) begin
                  state      <= S_REPORT;
                  busy       <= 1'b0;
                  res_valid  <= 1'b1;
                  res_c1x    <= '0;
                  res_c1y    <= '0;
                  res_c2x    <= '0;
                  res_c2y    <= '0;
                  res_cycles <= TMO;
                  timeout    <= 1'b1;
               end else if (cnt != CNT_MAX) begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_REPORT: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_laser_point_driver.sv
// tb_laser_point_driver: table-driven and randomized runs of laser_point_driver
// against a cycle-schedule model of a run and a shadow copy of the pattern.
module tb_laser_point_driver;

   localparam int NPTS = 40;
   localparam int TMO  = 16;
   localparam int CNTW = 16;
   localparam int T    = 2 + NPTS;   // cycle index (after start edge) of the last point

   logic            CLK = 1'b0;
   logic            RST = 1'b1;
   logic            wr_en = 1'b0;
   logic [5:0]      wr_addr = '0;
   logic [3:0]      wr_x = '0;
   logic [3:0]      wr_y = '0;
   logic            start = 1'b0;
   logic            busy;
   logic            L_RST;
   logic [3:0]      L_X;
   logic [3:0]      L_Y;
   logic [3:0]      L_C1X = '0;
   logic [3:0]      L_C1Y = '0;
   logic [3:0]      L_C2X = '0;
   logic [3:0]      L_C2Y = '0;
   logic            L_DONE = 1'b0;
   logic            res_valid;
   logic [3:0]      res_c1x;
   logic [3:0]      res_c1y;
   logic [3:0]      res_c2x;
   logic [3:0]      res_c2y;
   logic [CNTW-1:0] res_cycles;
   logic            timeout;
   logic            proto_err;

   int checks = 0;
   int failures = 0;
   logic [7:0] ref_mem [NPTS];

   always #5 CLK = ~CLK;

   laser_point_driver #(.NPTS(NPTS), .TIMEOUT(TMO), .CNTW(CNTW)) dut (
      .CLK(CLK), .RST(RST), .wr_en(wr_en), .wr_addr(wr_addr), .wr_x(wr_x), .wr_y(wr_y),
      .start(start), .busy(busy), .L_RST(L_RST), .L_X(L_X), .L_Y(L_Y),
      .L_C1X(L_C1X), .L_C1Y(L_C1Y), .L_C2X(L_C2X), .L_C2Y(L_C2Y), .L_DONE(L_DONE),
      .res_valid(res_valid), .res_c1x(res_c1x), .res_c1y(res_c1y), .res_c2x(res_c2x),
      .res_c2y(res_c2y), .res_cycles(res_cycles), .timeout(timeout), .proto_err(proto_err)
   );

   typedef struct {
      string       name;
      int          done_d;     // DONE this many cycles after the last point; 0 = never
      int          early_c;    // extra DONE at this cycle after start edge; 0 = none
      logic [15:0] drv_c;      // {C1X,C1Y,C2X,C2Y} driven by the core model
      bit          extra;      // mid-run start pulse and write attempt
      int          rst_at;     // assert RST during this cycle; 0 = none
      logic [15:0] exp_c;
      int          exp_cycles;
      bit          exp_to;
      bit          exp_pe;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_rstvals"},
          {busy, L_RST, L_X, L_Y, res_valid, res_c1x, res_c1y, res_c2x, res_c2y,
           res_cycles, timeout, proto_err},
          {1'b0, 1'b1, 8'h00, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0});
   endtask

   task automatic load(input int addr, input logic [3:0] x, input logic [3:0] y);
      wr_en   = 1'b1;
      wr_addr = addr[5:0];
      wr_x    = x;
      wr_y    = y;
      step();
      wr_en = 1'b0;
      if (addr < NPTS) ref_mem[addr] = {x, y};
   endtask

   // One complete run; every cycle is compared with the schedule the model predicts.
   task automatic run(input vec_t v);
      int fin;
      int rep_c;
      bit reported;
      fin      = (v.done_d >= 1 && v.done_d <= TMO) ? v.done_d : TMO;
      rep_c    = T + fin + 1;
      reported = 1'b0;
      {L_C1X, L_C1Y, L_C2X, L_C2Y} = v.drv_c;
      start = 1'b1;
      step();
      start = 1'b0;
      chk({v.name, "_flags_clr"}, {timeout, proto_err}, 2'b00);
      for (int c = 1; c <= T + TMO + 4 && !reported; c++) begin
         logic [7:0]  pt;
         logic [10:0] exp_v;
         if (c <= 2)      pt = 8'h00;
         else if (c <= T) pt = ref_mem[c-3];
         else             pt = ref_mem[NPTS-1];
         exp_v = {(c <= 2), (c != rep_c), (c == rep_c), pt};
         chk($sformatf("%s_c%0d", v.name, c), {L_RST, busy, res_valid, L_X, L_Y}, exp_v);
         if (c == rep_c) begin
            chk({v.name, "_result"},
                {res_c1x, res_c1y, res_c2x, res_c2y, res_cycles, timeout, proto_err},
                {v.exp_c, 16'(v.exp_cycles), v.exp_to, v.exp_pe});
            reported = 1'b1;
         end
         start  = 1'b0;
         wr_en  = 1'b0;
         L_DONE = (v.done_d >= 1 && c == T + v.done_d) || (c == v.early_c);
         if (v.extra && c == 13) begin
            start   = 1'b1;
            wr_en   = 1'b1;
            wr_addr = 6'd0;
            wr_x    = ~ref_mem[0][7:4];
            wr_y    = ~ref_mem[0][3:0];
         end
         if (v.rst_at > 0 && c == v.rst_at) RST = 1'b1;
         step();
         if (RST) begin
            RST    = 1'b0;
            L_DONE = 1'b0;
            check_reset_vals(v.name);
            step();
            chk({v.name, "_idle_after_rst"}, {L_RST, busy}, 2'b00);
            return;
         end
      end
      L_DONE = 1'b0;
      start  = 1'b0;
      wr_en  = 1'b0;
      chk({v.name, "_reported"}, reported, 1'b1);
      chk({v.name, "_hold"},
          {res_valid, busy, res_c1x, res_c1y, res_c2x, res_c2y, res_cycles, timeout, proto_err},
          {2'b00, v.exp_c, 16'(v.exp_cycles), v.exp_to, v.exp_pe});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t tbl[9];
      tbl[0] = '{"basic",    5,  0, 16'h32A4, 0, 0,  16'h32A4, 5,  0, 0};
      tbl[1] = '{"tmo",      0,  0, 16'h7777, 0, 0,  16'h0000, 16, 1, 0};
      tbl[2] = '{"early",    8, 13, 16'h1234, 0, 0,  16'h1234, 8,  0, 1};
      tbl[3] = '{"ignore",   3,  0, 16'h5A5A, 1, 0,  16'h5A5A, 3,  0, 0};
      tbl[4] = '{"replay",   5,  0, 16'h32A4, 0, 0,  16'h32A4, 5,  0, 0};
      tbl[5] = '{"coincide", 16, 0, 16'hF0E1, 0, 0,  16'hF0E1, 16, 0, 0};
      tbl[6] = '{"rstl_done", 4, 1, 16'hABCD, 0, 0,  16'hABCD, 4,  0, 0};
      tbl[7] = '{"midrst",   5,  0, 16'h1111, 0, 23, 16'h0000, 0,  0, 0};
      tbl[8] = '{"after_rst", 2, 0, 16'h9876, 0, 0,  16'h9876, 2,  0, 0};

      for (int i = 0; i < NPTS; i++) ref_mem[i] = 8'h00;
      RST = 1'b1;
      step();
      step();
      step();
      check_reset_vals("init");
      RST = 1'b0;
      step();
      chk("idle_lrst", {L_RST, busy}, 2'b00);

      load(0, 4'd11, 4'd0);
      load(1, 4'd2, 4'd1);
      load(2, 4'd10, 4'd1);
      for (int i = 3; i < NPTS; i++) load(i, 4'd0, 4'd0);

      for (int i = 0; i < 9; i++) run(tbl[i]);

      for (int r = 0; r < 10; r++) begin
         vec_t v;
         for (int w = 0; w < 50; w++) begin
            load($urandom_range(0, 63), 4'($urandom), 4'($urandom));
         end
         v.name    = $sformatf("rnd%0d", r);
         v.done_d  = $urandom_range(0, TMO + 3);
         v.early_c = ($urandom_range(0, 1) == 1) ? $urandom_range(1, T) : 0;
         v.drv_c   = 16'($urandom);
         v.extra   = 1'b0;
         v.rst_at  = 0;
         v.exp_to  = !(v.done_d >= 1 && v.done_d <= TMO);
         v.exp_c   = v.exp_to ? 16'h0000 : v.drv_c;
         v.exp_cycles = v.exp_to ? TMO : v.done_d;
         v.exp_pe  = (v.early_c >= 3);
         run(v);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
